// File: rtl/proc_seq_ctrl.sv
// proc_seq_ctrl: multi-cycle fetch/execute sequencer for the 8-bit, 4-register datapath.
// Each instruction is fetched over a request/valid port and then executed. The
// register-file write port is shared between instruction write-back and a host port.
// The host port is served only in IDLE and HALT.
//
// Instruction byte: [7:6] opcode (00 NOP, 01 ADD, 10 SUB, 11 HALT), [5:4] dst,
// [3:2] src a, [1:0] src b.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             level; begin execution from IDLE or resume from HALT
//   imem_req/addr     instruction read request, address (= pc)
//   imem_rvalid/rdata instruction read response
//   host_wr_en/sel/data, host_wr_ack  host register write; ack is combinational
//   pc, r0..r3        architectural state
//   busy, halted      FETCH/EXEC and HALT status
//   retire            one-cycle pulse per retired instruction
//   instr_cnt         saturating retire count (only with PROC_SEQ_INSTR_CNT_EN)
//
// Optional feature macro: PROC_SEQ_INSTR_CNT_EN
module proc_seq_ctrl #(
  parameter int unsigned   DW       = 8,
  parameter int unsigned   AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          host_wr_en,
  input  logic [1:0]    host_wr_sel,
  input  logic [DW-1:0] host_wr_data,
  output logic          host_wr_ack,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3,
  output logic          busy,
  output logic          halted,
  output logic          retire
`ifdef PROC_SEQ_INSTR_CNT_EN
  ,
  output logic [7:0]    instr_cnt
`endif
);

  localparam int unsigned NREG  = 4;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  state_e                   state_q, state_d;
  logic [NREG-1:0][DW-1:0]  regs;
  logic [DW-1:0]            ir, ir_d;
  logic [AW-1:0]            pc_d;
  logic                     retire_d;
  logic                     wb_en;
  logic [DW-1:0]            wb_data;
  op_e                      op;
  logic [1:0]               dst_sel;
  logic [DW-1:0]            src_a, src_b;

  // Instruction field decode from the held instruction register
  assign op      = op_e'(ir[7:6]);
  assign dst_sel = ir[5:4];
  assign src_a   = regs[ir[3:2]];
  assign src_b   = regs[ir[1:0]];

  assign imem_addr = pc;
  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];

  // Next-state, write-back and host-arbitration logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    ir_d        = ir;
    retire_d    = 1'b0;
    host_wr_ack = 1'b0;
    wb_en       = 1'b0;
    wb_data     = '0;
    case (state_q)
      ST_IDLE: begin
        // Host write wins; start is re-sampled on the following cycle
        if (host_wr_en) begin
          host_wr_ack = 1'b1;
        end else if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_rvalid) begin
          ir_d     = imem_rdata;
          state_d  = ST_EXEC;
          // Registered so the pulse lines up with the EXEC cycle
          retire_d = (imem_rdata[7:6] != OP_HALT);
        end
      end
      ST_EXEC: begin
        case (op)
          OP_NOP: begin
            pc_d    = pc + AW'(1);
            state_d = ST_FETCH;
          end
          OP_ADD: begin
            wb_en   = 1'b1;
            wb_data = src_a + src_b;
            pc_d    = pc + AW'(1);
            state_d = ST_FETCH;
          end
          OP_SUB: begin
            wb_en   = 1'b1;
            wb_data = src_a - src_b;
            pc_d    = pc + AW'(1);
            state_d = ST_FETCH;
          end
          default: begin
            state_d = ST_HALT;
          end
        endcase
      end
      ST_HALT: begin
        if (host_wr_en) begin
          host_wr_ack = 1'b1;
        end else if (start) begin
          // Resume skips past the HALT instruction
          pc_d    = pc + AW'(1);
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pc, ir and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      retire   <= 1'b0;
      imem_req <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc       <= pc_d;
      ir       <= ir_d;
      retire   <= retire_d;
      imem_req <= (state_d == ST_FETCH);
      busy     <= (state_d == ST_FETCH) || (state_d == ST_EXEC);
      halted   <= (state_d == ST_HALT);
    end
  end

  // Register file: host and write-back are never active in the same state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (host_wr_ack) begin
      regs[host_wr_sel] <= host_wr_data;
    end else if (wb_en) begin
      regs[dst_sel] <= wb_data;
    end
  end

`ifdef PROC_SEQ_INSTR_CNT_EN
  // Saturating retire counter, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
    end else if (retire && (instr_cnt != {CNT_W{1'b1}})) begin
      instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// tb_proc_seq_ctrl: scoreboard bench for proc_seq_ctrl. Programs are evaluated by an
// instruction-level model when issued, and the expected state after each instruction
// is queued. A monitor pops and compares on each retire and on entry to HALT. A memory
// responder serves fetches with random or fixed stalls.
module tb_proc_seq_ctrl;

  typedef struct packed {
    logic            is_halt;
    logic [7:0]      pc;
    logic [3:0][7:0] r;
    logic [7:0]      cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_rvalid;
  logic [7:0] imem_rdata;
  logic       host_wr_en = 1'b0;
  logic [1:0] host_wr_sel = 2'd0;
  logic [7:0] host_wr_data = 8'd0;
  logic       host_wr_ack;
  logic [7:0] pc, r0, r1, r2, r3;
  logic       busy, halted, retire;
`ifdef PROC_SEQ_INSTR_CNT_EN
  logic [7:0] instr_cnt;
`endif

  proc_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .host_wr_en(host_wr_en), .host_wr_sel(host_wr_sel),
    .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
    .pc(pc), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .busy(busy), .halted(halted), .retire(retire)
`ifdef PROC_SEQ_INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ret_pulses = 0;

  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  logic [7:0] prog_q[$];
  logic [7:0] build_q[$];

  // Instruction-level reference model
  int              m_pc = 0;
  logic [3:0][7:0] m_r = '0;
  bit              m_halted = 1'b0;
  int              m_ret = 0;

  int stall_fixed = -1;
  bit mem_hold = 1'b0;
  bit stray_req = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endfunction

  function automatic logic [7:0] dut_reg(input logic [1:0] s);
    case (s)
      2'd0: return r0;
      2'd1: return r1;
      2'd2: return r2;
      default: return r3;
    endcase
  endfunction

  function automatic exp_t make_rec(input logic is_halt);
    exp_t e;
    e.is_halt = is_halt;
    e.pc      = 8'(m_pc);
    e.r       = m_r;
    e.cnt     = (m_ret > 255) ? 8'd255 : 8'(m_ret);
    return e;
  endfunction

  // Evaluate build_q in the model and queue fetch addresses, memory bytes and results
  task automatic issue_program(output int n);
    logic [7:0] ins;
    if (m_halted) begin
      m_pc = (m_pc + 1) & 255;
      m_halted = 1'b0;
    end
    n = build_q.size();
    foreach (build_q[i]) begin
      ins = build_q[i];
      addr_q.push_back(8'(m_pc));
      prog_q.push_back(ins);
      if (ins[7:6] == 2'b11) begin
        m_halted = 1'b1;
        exp_q.push_back(make_rec(1'b1));
        break;
      end
      if (ins[7:6] == 2'b01) m_r[ins[5:4]] = m_r[ins[3:2]] + m_r[ins[1:0]];
      else if (ins[7:6] == 2'b10) m_r[ins[5:4]] = m_r[ins[3:2]] - m_r[ins[1:0]];
      m_pc = (m_pc + 1) & 255;
      m_ret++;
      exp_q.push_back(make_rec(1'b0));
    end
    build_q.delete();
  endtask

  task automatic kick();
    bit ok = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin ok = 1'b1; break; end
    end
    start = 1'b0;
    if (!ok) fail_evt("start_timeout");
  endtask

  task automatic wait_halt(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_evt("halt_timeout");
  endtask

  task automatic run_program();
    int n;
    issue_program(n);
    kick();
    wait_halt(n * 12 + 50);
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [7:0] d);
    bit got = 1'b0;
    @(negedge clk);
    host_wr_en = 1'b1; host_wr_sel = sel; host_wr_data = d;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (host_wr_ack) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) begin
      fail_evt("host_ack_timeout");
      host_wr_en = 1'b0;
    end else begin
      chk("ack_only_when_not_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      host_wr_en = 1'b0;
      m_r[sel] = d;
      chk("host_write_lands", 32'(dut_reg(sel)), 32'(d));
    end
  endtask

  task automatic clear_model();
    addr_q.delete(); prog_q.delete(); exp_q.delete(); build_q.delete();
    m_pc = 0; m_r = '0; m_halted = 1'b0; m_ret = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; host_wr_en = 1'b0; mem_hold = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: results are visible the cycle after retire
  initial begin
    bit   prev_ret;
    bit   prev_halt;
    exp_t e;
    prev_ret = 1'b0;
    prev_halt = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin prev_ret = 1'b0; prev_halt = 1'b0; continue; end
      if (retire) ret_pulses++;
      if (prev_ret) begin
        if (exp_q.size() == 0) fail_evt("unexpected_retire");
        else begin
          e = exp_q.pop_front();
          chk("retire_kind", 32'(e.is_halt), 32'd0);
          chk("retire_pc", 32'(pc), 32'(e.pc));
          chk("retire_regs", 32'({r3, r2, r1, r0}), 32'(e.r));
`ifdef PROC_SEQ_INSTR_CNT_EN
          chk("retire_cnt", 32'(instr_cnt), 32'(e.cnt));
`endif
        end
      end
      if (halted && !prev_halt) begin
        if (exp_q.size() == 0) fail_evt("unexpected_halt");
        else begin
          e = exp_q.pop_front();
          chk("halt_kind", 32'(e.is_halt), 32'd1);
          chk("halt_pc", 32'(pc), 32'(e.pc));
          chk("halt_regs", 32'({r3, r2, r1, r0}), 32'(e.r));
          chk("halt_busy", 32'(busy), 32'd0);
`ifdef PROC_SEQ_INSTR_CNT_EN
          chk("halt_cnt", 32'(instr_cnt), 32'(e.cnt));
`endif
        end
      end
      if (host_wr_en && busy) chk("ack_blocked_busy", 32'(host_wr_ack), 32'd0);
      prev_ret = retire;
      prev_halt = halted;
    end
  end

  // Instruction memory responder
  initial begin
    bit         in_fetch;
    bit         delivered;
    int         stall;
    int         stall_init;
    int         reqc;
    logic [7:0] faddr;
    in_fetch = 1'b0; delivered = 1'b0; stall = 0; stall_init = 0; reqc = 0; faddr = 8'd0;
    imem_rvalid = 1'b0;
    imem_rdata = 8'd0;
    forever begin
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      if (rst) begin in_fetch = 1'b0; delivered = 1'b0; continue; end
      if (delivered) begin
        chk("req_drops_after_rvalid", 32'(imem_req), 32'd0);
        delivered = 1'b0;
      end
      if (stray_req) begin
        stray_req = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 8'h49;
        continue;
      end
      if (imem_req) begin
        if (!in_fetch) begin
          in_fetch = 1'b1;
          reqc = 0;
          faddr = imem_addr;
          stall_init = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
          stall = stall_init;
          if (addr_q.size() == 0) fail_evt("unexpected_fetch");
          else chk("fetch_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
        end else begin
          chk("fetch_addr_stable", 32'(imem_addr), 32'(faddr));
        end
        chk("busy_in_fetch", 32'(busy), 32'd1);
        reqc++;
        if (!mem_hold) begin
          if (stall == 0) begin
            imem_rvalid = 1'b1;
            if (prog_q.size() == 0) begin
              fail_evt("fetch_without_program");
              imem_rdata = 8'hC0;
            end else begin
              imem_rdata = prog_q.pop_front();
            end
            chk("fetch_req_cycles", 32'(reqc), 32'(stall_init + 1));
            in_fetch = 1'b0;
            delivered = 1'b1;
          end else begin
            stall--;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ret0;
    logic [7:0] v;

    // Reset state
    #12;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_regs", 32'({r3, r2, r1, r0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
`ifdef PROC_SEQ_INSTR_CNT_EN
    chk("rst_cnt", 32'(instr_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Stray rvalid while IDLE
    @(negedge clk);
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_pc", 32'(pc), 32'd0);
    chk("stray_regs", 32'({r3, r2, r1, r0}), 32'd0);
    chk("stray_no_retire", 32'(ret_pulses), 32'd0);

    // ADD r0,r2,r1 then HALT
    host_write(2'd1, 8'h05);
    host_write(2'd2, 8'h03);
    ret0 = ret_pulses;
    build_q = '{8'h49, 8'hC0};
    run_program();
    chk("basic_r0", 32'(r0), 32'h08);
    chk("basic_pc", 32'(pc), 32'd1);
    chk("basic_halted", 32'(halted), 32'd1);
    chk("basic_retires", 32'(ret_pulses - ret0), 32'd1);
`ifdef PROC_SEQ_INSTR_CNT_EN
    chk("basic_cnt", 32'(instr_cnt), 32'd1);
`endif

    // Data wrap, SUB, pc wrap: ADD at 0xFF, SUB at 0x00, HALT at 0x01
    host_write(2'd3, 8'hFF);
    host_write(2'd1, 8'h02);
    host_write(2'd0, 8'h00);
    n = (255 - ((m_pc + 1) & 255)) & 255;
    for (int i = 0; i < n; i++) build_q.push_back(8'h00);
    build_q.push_back(8'h7D);
    build_q.push_back(8'h81);
    build_q.push_back(8'hC0);
    run_program();
    chk("wrap_r3", 32'(r3), 32'h01);
    chk("wrap_r0", 32'(r0), 32'hFE);
    chk("wrap_pc", 32'(pc), 32'h01);

    // Memory stall of 5 cycles
    stall_fixed = 5;
    build_q = '{8'h00, 8'hC0};
    run_program();
    stall_fixed = -1;

    // Host write during execution waits for HALT
    for (int i = 0; i < 8; i++) build_q.push_back({2'(int'($urandom_range(0, 2))), 6'($urandom)});
    build_q.push_back(8'hC0);
    issue_program(n);
    kick();
    fork
      host_write(2'd2, 8'hA5);
      wait_halt(n * 12 + 50);
    join

    // Host write and start together in IDLE: write first, FETCH next cycle
    do_reset();
    m_r[1] = 8'h07;
    build_q = '{8'h45, 8'hC0};
    issue_program(n);
    @(negedge clk);
    host_wr_en = 1'b1; host_wr_sel = 2'd1; host_wr_data = 8'h07; start = 1'b1;
    #1;
    chk("both_ack", 32'(host_wr_ack), 32'd1);
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    chk("both_write_first", 32'(r1), 32'h07);
    chk("both_still_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("both_fetch_next", 32'(busy), 32'd1);
    start = 1'b0;
    wait_halt(50);
    chk("both_r0", 32'(r0), 32'h0E);

    // Asynchronous reset in mid-FETCH
    build_q = '{8'h00, 8'hC0};
    issue_program(n);
    mem_hold = 1'b1;
    kick();
    @(negedge clk);
    chk("hold_in_fetch", 32'(imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_imem_req", 32'(imem_req), 32'd0);
    chk("arst_regs", 32'({r3, r2, r1, r0}), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    clear_model();
    mem_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle_busy", 32'(busy), 32'd0);
    chk("arst_idle_halted", 32'(halted), 32'd0);
    chk("arst_idle_req", 32'(imem_req), 32'd0);

    // 300 NOPs then HALT from reset
    ret0 = ret_pulses;
    for (int i = 0; i < 300; i++) build_q.push_back(8'h00);
    build_q.push_back(8'hC0);
    run_program();
    chk("nop300_pc", 32'(pc), 32'h2C);
    chk("nop300_retires", 32'(ret_pulses - ret0), 32'd300);
`ifdef PROC_SEQ_INSTR_CNT_EN
    chk("nop300_cnt", 32'(instr_cnt), 32'd255);
`endif

    // Random programs with random host writes between runs
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 2; j++) begin
        v = 8'($urandom);
        host_write(2'($urandom_range(0, 3)), v);
      end
      n = int'($urandom_range(5, 20));
      for (int i = 0; i < n; i++) build_q.push_back({2'(int'($urandom_range(0, 2))), 6'($urandom)});
      build_q.push_back(8'hC0);
      run_program();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("fetches_drained", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
